// File: rtl/hazard_ctrl.sv
// Hazard control unit sitting at the consuming end of the ID/EX register.
// Detects load-use hazards, taken-branch redirects and data-memory waits, and
// drives the PC/IF/ID stall, the IF/ID and ID/EX bubble controls and the PC
// redirect. A multi-cycle load-use stall counter, a memory-wait state and two
// saturating event counters are kept here.
module hazard_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  ifidRS,
    input  logic [REG_W-1:0]  ifidRT,
    input  logic              ifidUsesRS,
    input  logic              ifidUsesRT,
    input  logic              idexIsLoadInsn,
    input  logic              idexRfWrEnable,
    input  logic [REG_W-1:0]  idexDstReg,
    input  logic              exBrTaken,
    input  logic [ADDR_W-1:0] exBrTarget,
    input  logic              memReady,
    input  logic              memAccess,
    output logic              pcStall,
    output logic              ifidStall,
    output logic              idexFlush,
    output logic              ifidFlush,
    output logic              pcRedirect,
    output logic [ADDR_W-1:0] pcRedirectAddr,
    output logic [CNT_W-1:0]  stallCycles,
    output logic [CNT_W-1:0]  flushEvents
);

    typedef enum logic [1:0] {StRun, StLdStall, StMemWait} state_e;

    // Remaining bubbles after the first one; LOAD_LAT is at most 7.
    localparam logic [2:0] LatInit = 3'(LOAD_LAT - 1);

    state_e           state_q, state_d;
    logic [2:0]       lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_wait;
    logic ld_pending;
    logic pc_stall_c;
    logic idex_flush_c;
    logic redirect_c;

    assign load_use = idexIsLoadInsn && idexRfWrEnable && (idexDstReg != '0) &&
                      ((ifidUsesRS && (ifidRS == idexDstReg)) ||
                       (ifidUsesRT && (ifidRT == idexDstReg)));
    assign mem_wait = memAccess && !memReady;

    // A load-use stall interrupted by a memory wait keeps its count and resumes.
    assign ld_pending = (state_q == StLdStall) ||
                        ((state_q == StMemWait) && (lat_cnt_q != '0));

    // Next state, counters and raw (ungated) control outputs, in priority order.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_stall_c   = 1'b0;
        idex_flush_c = 1'b0;
        redirect_c   = 1'b0;

        if (mem_wait) begin
            // Whole pipeline frozen; a taken branch in EX will be re-presented.
            pc_stall_c = 1'b1;
            state_d    = StMemWait;
        end else if (exBrTaken) begin
            redirect_c   = 1'b1;
            idex_flush_c = 1'b1;
            state_d      = StRun;
            lat_cnt_d    = '0;
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else if (ld_pending) begin
            pc_stall_c   = 1'b1;
            idex_flush_c = 1'b1;
            lat_cnt_d    = lat_cnt_q - 3'd1;
            state_d      = (lat_cnt_d == '0) ? StRun : StLdStall;
        end else begin
            state_d = StRun;
            if (load_use) begin
                pc_stall_c   = 1'b1;
                idex_flush_c = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_d   = StLdStall;
                    lat_cnt_d = LatInit;
                end
            end
        end

        if (pc_stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            lat_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted so nothing glitches high.
    always_comb begin
        pcStall        = rst && pc_stall_c;
        ifidStall      = rst && pc_stall_c;
        idexFlush      = rst && idex_flush_c;
        ifidFlush      = rst && redirect_c;
        pcRedirect     = rst && redirect_c;
        pcRedirectAddr = (rst && redirect_c) ? exBrTarget : '0;
    end

    assign stallCycles = stall_cnt_q;
    assign flushEvents = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3, LOAD_LAT=3 with
// 4-bit counters) share one stimulus stream and are checked against a
// bubble-count model kept here.
module tb_hazard_ctrl;

    localparam int N = 3;

    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        ld;
        logic        we;
        logic [4:0]  dst;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        acc;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ifidRS = '0, ifidRT = '0, idexDstReg = '0;
    logic        ifidUsesRS = 1'b0, ifidUsesRT = 1'b0;
    logic        idexIsLoadInsn = 1'b0, idexRfWrEnable = 1'b0;
    logic        exBrTaken = 1'b0, memReady = 1'b1, memAccess = 1'b0;
    logic [31:0] exBrTarget = '0;

    logic        ps0, is0, idf0, iff0, pr0;
    logic        ps1, is1, idf1, iff1, pr1;
    logic        ps2, is2, idf2, iff2, pr2;
    logic [31:0] pa0, pa1, pa2;
    logic [15:0] sc0, fe0, sc1, fe1;
    logic [3:0]  sc2, fe2;

    // {pcStall, ifidStall, idexFlush, ifidFlush, pcRedirect}
    logic [4:0]  ctl  [N];
    logic [31:0] addr [N];
    logic [15:0] sc   [N];
    logic [15:0] fe   [N];

    assign ctl[0]  = {ps0, is0, idf0, iff0, pr0};
    assign ctl[1]  = {ps1, is1, idf1, iff1, pr1};
    assign ctl[2]  = {ps2, is2, idf2, iff2, pr2};
    assign addr[0] = pa0;
    assign addr[1] = pa1;
    assign addr[2] = pa2;
    assign sc[0]   = sc0;
    assign sc[1]   = sc1;
    assign sc[2]   = {12'd0, sc2};
    assign fe[0]   = fe0;
    assign fe[1]   = fe1;
    assign fe[2]   = {12'd0, fe2};

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .ifidRS(ifidRS), .ifidRT(ifidRT),
        .ifidUsesRS(ifidUsesRS), .ifidUsesRT(ifidUsesRT),
        .idexIsLoadInsn(idexIsLoadInsn), .idexRfWrEnable(idexRfWrEnable),
        .idexDstReg(idexDstReg), .exBrTaken(exBrTaken), .exBrTarget(exBrTarget),
        .memReady(memReady), .memAccess(memAccess),
        .pcStall(ps0), .ifidStall(is0), .idexFlush(idf0), .ifidFlush(iff0),
        .pcRedirect(pr0), .pcRedirectAddr(pa0), .stallCycles(sc0), .flushEvents(fe0)
    );

    hazard_ctrl #(.LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .ifidRS(ifidRS), .ifidRT(ifidRT),
        .ifidUsesRS(ifidUsesRS), .ifidUsesRT(ifidUsesRT),
        .idexIsLoadInsn(idexIsLoadInsn), .idexRfWrEnable(idexRfWrEnable),
        .idexDstReg(idexDstReg), .exBrTaken(exBrTaken), .exBrTarget(exBrTarget),
        .memReady(memReady), .memAccess(memAccess),
        .pcStall(ps1), .ifidStall(is1), .idexFlush(idf1), .ifidFlush(iff1),
        .pcRedirect(pr1), .pcRedirectAddr(pa1), .stallCycles(sc1), .flushEvents(fe1)
    );

    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .ifidRS(ifidRS), .ifidRT(ifidRT),
        .ifidUsesRS(ifidUsesRS), .ifidUsesRT(ifidUsesRT),
        .idexIsLoadInsn(idexIsLoadInsn), .idexRfWrEnable(idexRfWrEnable),
        .idexDstReg(idexDstReg), .exBrTaken(exBrTaken), .exBrTarget(exBrTarget),
        .memReady(memReady), .memAccess(memAccess),
        .pcStall(ps2), .ifidStall(is2), .idexFlush(idf2), .ifidFlush(iff2),
        .pcRedirect(pr2), .pcRedirectAddr(pa2), .stallCycles(sc2), .flushEvents(fe2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bubbles still owed, and plain event tallies.
    int lat  [N] = '{1, 3, 3};
    int cmax [N] = '{65535, 65535, 15};
    int pend [N] = '{0, 0, 0};
    int stalls  [N] = '{0, 0, 0};
    int flushes [N] = '{0, 0, 0};

    logic [4:0]  exp_ctl  [N];
    logic [31:0] exp_addr [N];
    int          exp_sc   [N];
    int          exp_fe   [N];

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b1; s.rs = '0; s.rt = '0; s.urs = 1'b0; s.urt = 1'b0;
        s.ld = 1'b0; s.we = 1'b0; s.dst = '0; s.br = 1'b0; s.tgt = '0;
        s.rdy = 1'b1; s.acc = 1'b0;
        return s;
    endfunction

    function automatic stim_t load_use(input logic [4:0] r);
        stim_t s = idle();
        s.ld = 1'b1; s.we = 1'b1; s.dst = r; s.rs = r; s.urs = 1'b1;
        return s;
    endfunction

    // Apply one cycle of stimulus at the falling edge, then form expectations.
    task automatic step(input stim_t s);
        logic lu, mw, stall, fid, redir;
        @(negedge clk);
        rst = s.rst; ifidRS = s.rs; ifidRT = s.rt; ifidUsesRS = s.urs;
        ifidUsesRT = s.urt; idexIsLoadInsn = s.ld; idexRfWrEnable = s.we;
        idexDstReg = s.dst; exBrTaken = s.br; exBrTarget = s.tgt;
        memReady = s.rdy; memAccess = s.acc;
        #1;
        lu = s.ld && s.we && (s.dst != 0) &&
             ((s.urs && s.rs == s.dst) || (s.urt && s.rt == s.dst));
        mw = s.acc && !s.rdy;
        for (int i = 0; i < N; i++) begin
            if (!s.rst) begin
                pend[i] = 0; stalls[i] = 0; flushes[i] = 0;
                exp_ctl[i] = '0; exp_addr[i] = '0; exp_sc[i] = 0; exp_fe[i] = 0;
            end else begin
                exp_sc[i] = stalls[i];
                exp_fe[i] = flushes[i];
                stall = 1'b0; fid = 1'b0; redir = 1'b0;
                if (mw) stall = 1'b1;
                else if (s.br) redir = 1'b1;
                else if (pend[i] > 0 || lu) begin stall = 1'b1; fid = 1'b1; end
                exp_ctl[i]  = {stall, stall, fid | redir, redir, redir};
                exp_addr[i] = redir ? s.tgt : 32'd0;
                if (!mw) begin
                    if (s.br) begin
                        pend[i] = 0;
                        if (flushes[i] < cmax[i]) flushes[i]++;
                    end else if (pend[i] > 0) begin
                        pend[i]--;
                    end else if (lu) begin
                        pend[i] = lat[i] - 1;
                    end
                end
                if (stall && stalls[i] < cmax[i]) stalls[i]++;
            end
        end
    endtask

    task automatic do_reset();
        stim_t s = idle();
        s.rst = 1'b0;
        step(s);
    endtask

    task automatic test_reset();
        stim_t s = load_use(5'd5);
        s.rst = 1'b0; s.br = 1'b1; s.tgt = 32'h44;
        step(s);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (ctl[i] !== 5'b0 || addr[i] !== 32'd0 || sc[i] !== 16'd0 || fe[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset inst %0d: ctl=%b addr=%h sc=%0d fe=%0d, required all 0",
                         i, ctl[i], addr[i], sc[i], fe[i]);
            end
        end
        for (int c = 0; c < 10; c++) begin
            step(idle());
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (ctl[i] !== 5'b0 || addr[i] !== 32'd0 || sc[i] !== 16'd0 || fe[i] !== 16'd0) begin
                    n_fail++;
                    $display("FAIL idle inst %0d cyc %0d: ctl=%b addr=%h sc=%0d fe=%0d, required 0",
                             i, c, ctl[i], addr[i], sc[i], fe[i]);
                end
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        do_reset();
        step(load_use(5'd5));
        n_checks++;
        if (ctl[0] !== 5'b11100) begin
            n_fail++;
            $display("FAIL lu_stall: ctl=%b required 11100", ctl[0]);
        end
        step(idle());
        n_checks++;
        if (ctl[0] !== 5'b0 || sc[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_one_cycle: ctl=%b sc=%0d required 00000 / 1", ctl[0], sc[0]);
        end
        step(load_use(5'd0));
        n_checks++;
        if (ctl[0] !== 5'b0) begin
            n_fail++;
            $display("FAIL lu_r0: ctl=%b required 00000", ctl[0]);
        end
        s = idle();
        s.ld = 1'b1; s.we = 1'b1; s.dst = 5'd7; s.rt = 5'd7; s.urt = 1'b1; s.rs = 5'd9;
        step(s);
        n_checks++;
        if (ctl[0] !== 5'b11100) begin
            n_fail++;
            $display("FAIL lu_rt: ctl=%b required 11100", ctl[0]);
        end
        s.urt = 1'b0; s.rs = 5'd7;
        step(s);
        n_checks++;
        if (ctl[0] !== 5'b0) begin
            n_fail++;
            $display("FAIL lu_unused_src: ctl=%b required 00000", ctl[0]);
        end
    endtask

    task automatic test_branch_cancel();
        stim_t s = idle();
        do_reset();
        step(load_use(5'd3));
        n_checks++;
        if (ctl[1] !== 5'b11100) begin
            n_fail++;
            $display("FAIL bc_first: ctl=%b required 11100", ctl[1]);
        end
        s.br = 1'b1; s.tgt = 32'h40;
        step(s);
        n_checks++;
        if (ctl[1] !== 5'b00111 || addr[1] !== 32'h40) begin
            n_fail++;
            $display("FAIL bc_redirect: ctl=%b addr=%h required 00111 / 40", ctl[1], addr[1]);
        end
        step(idle());
        n_checks++;
        if (ctl[1] !== 5'b0 || sc[1] !== 16'd1 || fe[1] !== 16'd1) begin
            n_fail++;
            $display("FAIL bc_after: ctl=%b sc=%0d fe=%0d required 00000 / 1 / 1",
                     ctl[1], sc[1], fe[1]);
        end
    endtask

    task automatic test_mem_wait();
        stim_t s = idle();
        do_reset();
        s.acc = 1'b1; s.rdy = 1'b0; s.br = 1'b1; s.tgt = 32'h1234;
        for (int c = 0; c < 4; c++) begin
            step(s);
            n_checks++;
            if (ctl[0] !== 5'b11000 || addr[0] !== 32'd0) begin
                n_fail++;
                $display("FAIL mw_freeze cyc %0d: ctl=%b addr=%h required 11000 / 0",
                         c, ctl[0], addr[0]);
            end
        end
        s.rdy = 1'b1;
        step(s);
        n_checks++;
        if (ctl[0] !== 5'b00111 || addr[0] !== 32'h1234) begin
            n_fail++;
            $display("FAIL mw_release: ctl=%b addr=%h required 00111 / 1234", ctl[0], addr[0]);
        end
        step(idle());
        n_checks++;
        if (sc[0] !== 16'd4 || fe[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL mw_counts: sc=%0d fe=%0d required 4 / 1", sc[0], fe[0]);
        end
    endtask

    task automatic test_saturation();
        stim_t s = idle();
        do_reset();
        s.acc = 1'b1; s.rdy = 1'b0;
        for (int c = 0; c < 20; c++) step(s);
        step(idle());
        n_checks++;
        if (sc[2] !== 16'd15 || sc[0] !== 16'd20) begin
            n_fail++;
            $display("FAIL saturate: sc4=%0d sc16=%0d required 15 / 20", sc[2], sc[0]);
        end
    endtask

    task automatic test_reset_mid();
        stim_t s;
        do_reset();
        step(load_use(5'd9));
        step(idle());
        n_checks++;
        if (ctl[1] !== 5'b11100) begin
            n_fail++;
            $display("FAIL rm_ldstall: ctl=%b required 11100", ctl[1]);
        end
        s = load_use(5'd9);
        s.rst = 1'b0; s.acc = 1'b1; s.rdy = 1'b0;
        step(s);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (ctl[i] !== 5'b0 || addr[i] !== 32'd0 || sc[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL rm_in_reset inst %0d: ctl=%b addr=%h sc=%0d required 0",
                         i, ctl[i], addr[i], sc[i]);
            end
        end
        step(idle());
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (ctl[i] !== 5'b0 || sc[i] !== 16'd0 || fe[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL rm_after inst %0d: ctl=%b sc=%0d fe=%0d required 0",
                         i, ctl[i], sc[i], fe[i]);
            end
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int c = 0; c < 400; c++) begin
            s.rst = ($urandom_range(63) != 0);
            s.rs  = 5'($urandom_range(3));
            s.rt  = 5'($urandom_range(3));
            s.dst = 5'($urandom_range(3));
            s.urs = 1'($urandom);
            s.urt = 1'($urandom);
            s.ld  = 1'($urandom);
            s.we  = ($urandom_range(3) != 0);
            s.br  = ($urandom_range(7) == 0);
            s.tgt = $urandom;
            s.acc = ($urandom_range(2) == 0);
            s.rdy = 1'($urandom);
            step(s);
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (ctl[i] !== exp_ctl[i] || addr[i] !== exp_addr[i] ||
                    sc[i] !== 16'(exp_sc[i]) || fe[i] !== 16'(exp_fe[i])) begin
                    n_fail++;
                    $display("FAIL rand inst %0d cyc %0d: ctl=%b addr=%h sc=%0d fe=%0d required %b %h %0d %0d",
                             i, c, ctl[i], addr[i], sc[i], fe[i],
                             exp_ctl[i], exp_addr[i], exp_sc[i], exp_fe[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_cancel();
        test_mem_wait();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard control unit at the consuming end of the ID/EX pipeline register.
- Inspects the instruction held in ID/EX (load, destination register, write enable) against the instruction in IF/ID, and tracks branch resolution in EX and data-memory readiness.
- Generates the cHazard (bubble-insert) input of the ID/EX register, the IF/ID flush, PC/IF/ID stall and PC redirect.
- Sequential: multi-cycle load-use stall counter, memory-wait FSM, saturating event counters.

Parameters:
ADDR_W, 32, instruction address width (InsnAddrPath)
REG_W, 5, register number width (RegNumPath)
LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 16, width of event counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
ifidRS  in  REG_W  source register A of the instruction in IF/ID
ifidRT  in  REG_W  source register B of the instruction in IF/ID
ifidUsesRS  in  1  IF/ID instruction reads RS
ifidUsesRT  in  1  IF/ID instruction reads RT
idexIsLoadInsn  in  1  ID/EX holds a load
idexRfWrEnable  in  1  ID/EX instruction writes the register file
idexDstReg  in  REG_W  destination register of the ID/EX instruction (RT or RD, already selected)
exBrTaken  in  1  branch/jump in EX resolved taken this cycle
exBrTarget  in  ADDR_W  resolved target address
memReady  in  1  data memory can complete the MEM-stage access this cycle
memAccess  in  1  MEM stage holds a load or store
pcStall  out  1  hold PC
ifidStall  out  1  hold IF/ID
idexFlush  out  1  drives ID/EX cHazard: load a bubble
ifidFlush  out  1  load a bubble into IF/ID
pcRedirect  out  1  PC loads pcRedirectAddr next edge
pcRedirectAddr  out  ADDR_W  redirect target
stallCycles  out  CNT_W  saturating count of cycles with pcStall=1
flushEvents  out  CNT_W  saturating count of taken-branch redirects

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, load counter=0, stallCycles=0, flushEvents=0. All control outputs are 0; pcRedirectAddr=0.
- Outputs are combinational from state and current inputs (Mealy). They act in the same cycle the condition is seen. State and counters update on posedge clk.
- loadUse = idexIsLoadInsn & idexRfWrEnable & idexDstReg!=0 & ((ifidUsesRS & ifidRS==idexDstReg) | (ifidUsesRT & ifidRT==idexDstReg)).
- memWait = memAccess & ~memReady.
- States: RUN, LD_STALL, MEM_WAIT.
- Priority per cycle is memWait > exBrTaken > loadUse/LD_STALL.
- MEM_WAIT (entered or held when memWait=1, from any state):
  - pcStall=ifidStall=1; idexFlush=ifidFlush=pcRedirect=0, so the whole pipeline freezes.
  - A taken branch is not acted on while memWait=1; EX is frozen, so it is re-presented.
  - Leaves MEM_WAIT on the first cycle memWait=0 and evaluates that cycle as RUN, with a pending load counter resumed.
- Taken branch (memWait=0, exBrTaken=1):
  - pcRedirect=1, pcRedirectAddr=exBrTarget, ifidFlush=1, idexFlush=1.
  - pcStall=ifidStall=0.
  - Any load-use stall in progress is cancelled (counter to 0, state to RUN).
  - flushEvents increments.
- Load-use (memWait=0, exBrTaken=0):
  - In RUN with loadUse=1: pcStall=ifidStall=idexFlush=1.
  - If LOAD_LAT>1, go to LD_STALL with counter=LOAD_LAT-1.
  - In LD_STALL: same outputs; counter decrements each cycle; returns to RUN when the counter reaches 0.
  - LOAD_LAT=1 never enters LD_STALL.
- stallCycles increments on every cycle with pcStall=1.
- Both counters saturate at all-ones; there is no wrap.
- Register 0 never causes a hazard.
- Outputs never glitch high during reset.

Test Plan:
- Reset then idle: all inputs 0 for 10 cycles -> all outputs 0, counters 0.
- Load-use: idexIsLoadInsn=1, idexRfWrEnable=1, idexDstReg=5, ifidRS=5, ifidUsesRS=1, LOAD_LAT=1 -> exactly one cycle pcStall=ifidStall=idexFlush=1; stallCycles=1. Repeat with idexDstReg=0 -> no stall.
- LOAD_LAT=3 load-use, then exBrTaken=1 with exBrTarget=0x40 in the second stall cycle -> redirect to 0x40, ifidFlush=idexFlush=1, stall ends; flushEvents=1, stallCycles=1.
- memAccess=1, memReady=0 for 4 cycles with exBrTaken=1 held -> 4 cycles pcStall=ifidStall=1 and no redirect; redirect to target on the 5th cycle when memReady=1.
- Counter saturation (CNT_W=4): continuous memWait for 20 cycles -> stallCycles holds at 15.
- Assert rst=0 mid LD_STALL (LOAD_LAT=3) -> outputs 0 immediately, state RUN, counters 0 after release.
